// File: rtl/navigate_ctrl.sv
// navigate_ctrl: motion sequencer between the maze solver and the PID/motor path.
// Runs a heading change or a forward move. A forward move ramps the speed up,
// then ramps it back down when a wanted side opening appears or the path ahead
// closes, and finally returns a one-cycle mv_cmplt.
// Optional macro NAV_OPN_DBNC_EN: debounce the side-opening sensors over three
// hdng_rdy samples before a new opening is allowed to end a move.
module navigate_ctrl #(
  parameter logic [10:0] MAX_FRWRD = 11'h2A0,
  parameter logic [5:0]  FRWRD_INC = 6'h18
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        strt_hdng,
  input  logic        strt_mv,
  input  logic        stp_lft,
  input  logic        stp_rght,
  input  logic        hdng_rdy,
  input  logic        at_hdng,
  input  logic        lft_opn,
  input  logic        rght_opn,
  input  logic        frwrd_opn,
  output logic        mv_cmplt,
  output logic        moving,
  output logic        en_fusion,
  output logic [10:0] frwrd_spd
);

  typedef enum logic [1:0] {IDLE, HEADING, RAMP_UP, RAMP_DOWN} state_t;

  state_t      r_state, w_nxt_state;
  logic [10:0] r_spd, w_nxt_spd;
  logic        r_mv_cmplt, w_nxt_cmplt;
  logic        r_fast_dec, w_nxt_fast;
  logic        w_lft_rise, w_rght_rise;
  logic [11:0] w_up_sum, w_dn_step, w_dn_diff;
  logic [10:0] w_up_sat, w_dn_clamp;

  // Speed arithmetic is one bit wider than the command so the saturate and
  // clamp compares see the true result instead of a wrapped one.
  assign w_up_sum   = {1'b0, r_spd} + {6'd0, FRWRD_INC};
  assign w_dn_step  = r_fast_dec ? {4'd0, FRWRD_INC, 2'b00} : {5'd0, FRWRD_INC, 1'b0};
  assign w_dn_diff  = {1'b0, r_spd} - w_dn_step;
  assign w_up_sat   = (w_up_sum > {1'b0, MAX_FRWRD}) ? MAX_FRWRD : w_up_sum[10:0];
  assign w_dn_clamp = ({1'b0, r_spd} <= w_dn_step) ? 11'd0 : w_dn_diff[10:0];

`ifdef NAV_OPN_DBNC_EN
  // Sample history per side, newest sample in bit 0.
  logic [2:0] r_lft_sh, r_rght_sh;

  // Shift in a fresh sensor sample on every heading strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lft_sh  <= 3'b000;
      r_rght_sh <= 3'b000;
    end else if (hdng_rdy) begin
      r_lft_sh  <= {r_lft_sh[1:0], lft_opn};
      r_rght_sh <= {r_rght_sh[1:0], rght_opn};
    end
  end

  // History low,high,high plus a high sample now = three highs after a low.
  assign w_lft_rise  = hdng_rdy & lft_opn  & (r_lft_sh  == 3'b011);
  assign w_rght_rise = hdng_rdy & rght_opn & (r_rght_sh == 3'b011);
`else
  logic r_lft_q, r_rght_q;

  // Delay the opening sensors by one cycle for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lft_q  <= 1'b0;
      r_rght_q <= 1'b0;
    end else begin
      r_lft_q  <= lft_opn;
      r_rght_q <= rght_opn;
    end
  end

  assign w_lft_rise  = lft_opn  & ~r_lft_q;
  assign w_rght_rise = rght_opn & ~r_rght_q;
`endif

  // State, speed, completion pulse and decel-rate registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_spd      <= 11'd0;
      r_mv_cmplt <= 1'b0;
      r_fast_dec <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_spd      <= w_nxt_spd;
      r_mv_cmplt <= w_nxt_cmplt;
      r_fast_dec <= w_nxt_fast;
    end
  end

  // Next-state, next-speed and completion logic.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_spd   = r_spd;
    w_nxt_cmplt = 1'b0;
    w_nxt_fast  = r_fast_dec;
    case (r_state)
      IDLE: begin
        if (strt_hdng) begin
          w_nxt_state = HEADING;
        end else if (strt_mv) begin
          w_nxt_state = RAMP_UP;
          w_nxt_spd   = 11'd0;
          w_nxt_fast  = 1'b0;
        end
      end
      HEADING: begin
        w_nxt_spd = 11'd0;
        if (at_hdng) begin
          w_nxt_state = IDLE;
          w_nxt_cmplt = 1'b1;
        end
      end
      RAMP_UP: begin
        if (hdng_rdy) w_nxt_spd = w_up_sat;
        // A closed path ahead outranks a side opening: brake hard.
        if (!frwrd_opn) begin
          w_nxt_state = RAMP_DOWN;
          w_nxt_fast  = 1'b1;
        end else if ((stp_lft & w_lft_rise) | (stp_rght & w_rght_rise)) begin
          w_nxt_state = RAMP_DOWN;
          w_nxt_fast  = 1'b0;
        end
      end
      RAMP_DOWN: begin
        if (r_spd == 11'd0) begin
          w_nxt_state = IDLE;
          w_nxt_cmplt = 1'b1;
          w_nxt_fast  = 1'b0;
        end else begin
          if (hdng_rdy) w_nxt_spd = w_dn_clamp;
          // Upgraded rate applies from the following strobe onward.
          if (!frwrd_opn) w_nxt_fast = 1'b1;
        end
      end
      default: begin
        w_nxt_state = IDLE;
        w_nxt_spd   = 11'd0;
      end
    endcase
  end

  assign frwrd_spd = r_spd;
  assign mv_cmplt  = r_mv_cmplt;
  assign moving    = (r_state != IDLE);
  assign en_fusion = (r_spd > (MAX_FRWRD >> 1));

endmodule

// File: tb/tb_navigate_ctrl.sv
// Directed bench for navigate_ctrl: heading, ramp up/saturation, normal and
// fast ramp-down, opening edge rules, start priority and async reset mid-move.
module tb_navigate_ctrl;
  logic        clk, rst_n;
  logic        strt_hdng, strt_mv, stp_lft, stp_rght, hdng_rdy, at_hdng;
  logic        lft_opn, rght_opn, frwrd_opn;
  logic        mv_cmplt, moving, en_fusion;
  logic [10:0] frwrd_spd;

  int n_chk = 0;
  int n_err = 0;

  navigate_ctrl dut (
    .clk(clk), .rst_n(rst_n), .strt_hdng(strt_hdng), .strt_mv(strt_mv),
    .stp_lft(stp_lft), .stp_rght(stp_rght), .hdng_rdy(hdng_rdy), .at_hdng(at_hdng),
    .lft_opn(lft_opn), .rght_opn(rght_opn), .frwrd_opn(frwrd_opn),
    .mv_cmplt(mv_cmplt), .moving(moving), .en_fusion(en_fusion), .frwrd_spd(frwrd_spd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic strb();
    hdng_rdy = 1'b1;
    tick();
    hdng_rdy = 1'b0;
  endtask

  task automatic start_mv();
    strt_mv = 1'b1;
    tick();
    strt_mv = 1'b0;
  endtask

  task automatic ramp_max();
    start_mv();
    for (int k = 0; k < 28; k++) begin
      strb();
      idle(3);
    end
    chk("ramp_max_spd", frwrd_spd, 32'h2A0);
  endtask

  task automatic finish_pulse(input string tag);
    chk({tag, "_spd0"}, frwrd_spd, 0);
    chk({tag, "_cmplt_early"}, mv_cmplt, 0);
    tick();
    chk({tag, "_cmplt"}, mv_cmplt, 1);
    chk({tag, "_idle"}, moving, 0);
    tick();
    chk({tag, "_cmplt_1cyc"}, mv_cmplt, 0);
  endtask

  initial begin
    rst_n = 1'b0; strt_hdng = 0; strt_mv = 0; stp_lft = 0; stp_rght = 0;
    hdng_rdy = 0; at_hdng = 0; lft_opn = 0; rght_opn = 0; frwrd_opn = 1;
    idle(2);
    chk("rst_spd", frwrd_spd, 0);
    chk("rst_moving", moving, 0);
    chk("rst_cmplt", mv_cmplt, 0);
    chk("rst_fusion", en_fusion, 0);
    rst_n = 1'b1;
    tick();

    // Heading change
    strt_hdng = 1'b1;
    tick();
    strt_hdng = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("hdng_moving", moving, 1);
      chk("hdng_spd", frwrd_spd, 0);
      tick();
    end
    at_hdng = 1'b1;
    tick();
    at_hdng = 1'b0;
    chk("hdng_cmplt", mv_cmplt, 1);
    chk("hdng_idle", moving, 0);
    tick();
    chk("hdng_cmplt_1cyc", mv_cmplt, 0);

    // Ramp up to saturation with en_fusion threshold at 0x150
    start_mv();
    chk("ru_moving", moving, 1);
    chk("ru_spd0", frwrd_spd, 0);
    for (int k = 1; k <= 30; k++) begin
      int e;
      e = (k * 24 > 672) ? 672 : k * 24;
      strb();
      chk("ru_spd", frwrd_spd, e);
      chk("ru_fusion", en_fusion, (e > 336) ? 1 : 0);
      idle(3);
    end

`ifndef NAV_OPN_DBNC_EN
    // Left opening at max speed: normal decel 0x30 per strobe
    stp_lft = 1'b1;
    lft_opn = 1'b1;
    tick();
    for (int k = 1; k <= 14; k++) begin
      strb();
      chk("rd_spd", frwrd_spd, 672 - 48 * k);
      if (k < 14) idle(3);
    end
    finish_pulse("rd");
    stp_lft = 1'b0;
    lft_opn = 1'b0;
    tick();
`else
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
`endif

    // Forward path closes: fast decel 0x60 per strobe
    ramp_max();
    frwrd_opn = 1'b0;
    tick();
    for (int k = 1; k <= 7; k++) begin
      strb();
      chk("fd_spd", frwrd_spd, 672 - 96 * k);
      if (k < 7) idle(3);
    end
    finish_pulse("fd");
    frwrd_opn = 1'b1;

`ifndef NAV_OPN_DBNC_EN
    // Pre-existing right opening and wrong-side edge must not stop the move
    rght_opn = 1'b1; stp_rght = 1'b1;
    tick();
    start_mv();
    strb(); idle(3);
    strb(); idle(3);
    lft_opn = 1'b1;
    tick(); idle(3);
    strb();
    chk("noedge_moving", moving, 1);
    chk("noedge_spd", frwrd_spd, 72);
    rght_opn = 1'b0;
    tick();
    rght_opn = 1'b1;
    tick();
    chk("redge_hold", frwrd_spd, 72);
    strb();
    chk("redge_dec", frwrd_spd, 24);
    idle(3);
    strb();
    finish_pulse("redge_clamp");
    rght_opn = 1'b0; lft_opn = 1'b0; stp_rght = 1'b0;
    tick();

    // Single-cycle edge stops; decel clamps exactly at 0
    stp_lft = 1'b1;
    start_mv();
    strb(); idle(3);
    strb(); idle(3);
    lft_opn = 1'b1;
    tick();
    strb();
    finish_pulse("edge48");
    stp_lft = 1'b0; lft_opn = 1'b0;
    tick();
`else
    // Two-strobe glitch is ignored; three highs after a low end the move
    stp_lft = 1'b1;
    start_mv();
    strb(); idle(3);
    strb(); idle(3);
    lft_opn = 1'b1;
    strb(); idle(3);
    strb(); idle(3);
    lft_opn = 1'b0;
    strb(); idle(3);
    strb(); idle(3);
    chk("dbnc_moving", moving, 1);
    chk("dbnc_spd", frwrd_spd, 144);
    lft_opn = 1'b1;
    strb(); idle(3);
    strb(); idle(3);
    strb(); idle(3);
    chk("dbnc_peak", frwrd_spd, 216);
    strb();
    chk("dbnc_dec", frwrd_spd, 168);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; stp_lft = 1'b0; lft_opn = 1'b0;
    tick();
`endif

    // Simultaneous starts: heading wins, speed stays 0 on strobes
    strt_hdng = 1'b1; strt_mv = 1'b1;
    tick();
    strt_hdng = 1'b0; strt_mv = 1'b0;
    chk("prio_moving", moving, 1);
    strb();
    chk("prio_spd", frwrd_spd, 0);
    at_hdng = 1'b1;
    tick();
    at_hdng = 1'b0;
    chk("prio_cmplt", mv_cmplt, 1);
    tick();

    // Async reset mid-ramp
    start_mv();
    for (int k = 0; k < 15; k++) begin
      strb(); idle(3);
    end
    chk("mid_spd", frwrd_spd, 360);
    chk("mid_fusion", en_fusion, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_spd", frwrd_spd, 0);
    chk("arst_moving", moving, 0);
    chk("arst_fusion", en_fusion, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("arst_cmplt", mv_cmplt, 0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_cmplt", mv_cmplt, 0);
      chk("post_rst_moving", moving, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
